// File: rtl/pattern_pkg.sv
// Shared constants and FSM encoding for the frame loader and network.
// Row geometry, frame size, byte-index helpers.
package pattern_pkg;

    localparam int ROWS          = 6;
    localparam int ROW_BITS      = 56;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_ROW = ROW_BITS / BYTE_W;
    localparam int FRAME_BYTES   = ROWS * BYTES_PER_ROW;
    localparam int CNT_W         = 6;
    localparam int ROW_IDX_W     = 3;
    localparam int COL_IDX_W     = 3;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_CHECK  = S_CHECK,
        ST_COMMIT = S_COMMIT
    } state_e;

    function automatic logic [ROW_IDX_W-1:0] row_of(input logic [CNT_W-1:0] k);
        return ROW_IDX_W'(k / CNT_W'(BYTES_PER_ROW));
    endfunction

    function automatic logic [COL_IDX_W-1:0] col_of(input logic [CNT_W-1:0] k);
        return COL_IDX_W'(k % CNT_W'(BYTES_PER_ROW));
    endfunction

endpackage

// File: rtl/row_packer.sv
// One image row assembly register: writes a byte at a column index.
// Ports: clk, rst_n, clr_i, we_i, idx_i, data_i -> row_nxt_o.
module row_packer
    import pattern_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [COL_IDX_W-1:0] idx_i,
    input  logic [BYTE_W-1:0]    data_i,
    output logic [ROW_BITS-1:0]  row_nxt_o
);

    logic [ROW_BITS-1:0] row_q;
    logic [ROW_BITS-1:0] row_d;

    // Clear and write may coincide: a new frame's first byte lands
    // in a freshly cleared row.
    always_comb begin
        row_d = clr_i ? '0 : row_q;
        for (int b = 0; b < BYTES_PER_ROW; b++) begin
            if (we_i && idx_i == COL_IDX_W'(b)) begin
                row_d[ROW_BITS-1-BYTE_W*b -: BYTE_W] = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    // Next-state view lets the top commit the last byte on its own edge.
    assign row_nxt_o = row_d;

endmodule

// File: rtl/frame_loader.sv
// Packs a framed byte stream into six 56-bit rows; strobes data_enable.
// Ports: clk, reset(async low), in_* handshake, linear_mem1..6, frame_err.
// Optional trailing XOR checksum byte when FRAME_CHECKSUM_EN is defined.
module frame_loader
    import pattern_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                data_enable,
    output logic [ROW_BITS-1:0] linear_mem1,
    output logic [ROW_BITS-1:0] linear_mem2,
    output logic [ROW_BITS-1:0] linear_mem3,
    output logic [ROW_BITS-1:0] linear_mem4,
    output logic [ROW_BITS-1:0] linear_mem5,
    output logic [ROW_BITS-1:0] linear_mem6,
    output logic                frame_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rdy_q;
    logic               err_q, err_d;
    logic               we, clr, commit;
    logic [CNT_W-1:0]   wr_idx;
    logic [ROW_IDX_W-1:0] wr_row;
    logic [COL_IDX_W-1:0] wr_col;
    logic               acc;

    logic [ROW_BITS-1:0] buf_nxt [ROWS];
    logic [ROW_BITS-1:0] mem_q   [ROWS];

`ifdef FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0]  xor_q, xor_d;
`endif

    assign acc = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        we      = 1'b0;
        clr     = 1'b0;
        commit  = 1'b0;
        wr_idx  = cnt_q;
`ifdef FRAME_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (acc && in_sof) begin
                    clr     = 1'b1;
                    we      = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_LOAD;
`ifdef FRAME_CHECKSUM_EN
                    xor_d   = in_data;
`endif
                end
            end
            ST_LOAD: begin
                if (acc && in_sof) begin
                    // Abort: sof byte restarts the frame in place.
                    err_d   = 1'b1;
                    clr     = 1'b1;
                    we      = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = CNT_W'(1);
`ifdef FRAME_CHECKSUM_EN
                    xor_d   = in_data;
`endif
                end else if (acc) begin
                    we = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    xor_d = xor_q ^ in_data;
`endif
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_COMMIT;
                        commit  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (acc && in_sof) begin
                    err_d   = 1'b1;
                    clr     = 1'b1;
                    we      = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = CNT_W'(1);
                    xor_d   = in_data;
                    state_d = ST_LOAD;
                end else if (acc && in_data == xor_q) begin
                    commit  = 1'b1;
                    state_d = ST_COMMIT;
                end else if (acc) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_row = row_of(wr_idx);
    assign wr_col = col_of(wr_idx);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        row_packer u_row (
            .clk       (clk),
            .rst_n     (reset),
            .clr_i     (clr),
            .we_i      (we && wr_row == ROW_IDX_W'(r)),
            .idx_i     (wr_col),
            .data_i    (in_data),
            .row_nxt_o (buf_nxt[r])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Registered so it stays low while reset is held.
            rdy_q   <= (state_d != ST_COMMIT);
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (commit) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= buf_nxt[r];
            end
        end
    end

    assign in_ready    = rdy_q;
    assign data_enable = (state_q == ST_COMMIT);
    assign frame_err   = err_q;
    assign linear_mem1 = mem_q[0];
    assign linear_mem2 = mem_q[1];
    assign linear_mem3 = mem_q[2];
    assign linear_mem4 = mem_q[3];
    assign linear_mem5 = mem_q[4];
    assign linear_mem6 = mem_q[5];

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader.
// Build with FRAME_CHECKSUM_EN to cover the checksum variant.
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        data_enable;
    logic [55:0] linear_mem1, linear_mem2, linear_mem3;
    logic [55:0] linear_mem4, linear_mem5, linear_mem6;
    logic        frame_err;

    int tests  = 0;
    int failed = 0;
    int de_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int rdy_lo = 0;

    logic [7:0] fb [42];

    frame_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .data_enable (data_enable),
        .linear_mem1 (linear_mem1),
        .linear_mem2 (linear_mem2),
        .linear_mem3 (linear_mem3),
        .linear_mem4 (linear_mem4),
        .linear_mem5 (linear_mem5),
        .linear_mem6 (linear_mem6),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (data_enable) de_cnt++;
            if (frame_err) err_cnt++;
            if (data_enable && frame_err) both_cnt++;
            if (!in_ready) rdy_lo++;
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic s);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tests++;
            failed++;
            $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int start, input bit toggle, input bit bad);
        logic [7:0] ck;
        ck = 8'h00;
        for (int i = 0; i < 42; i++) ck = ck ^ fb[i];
        for (int i = start; i < 42; i++) begin
            send_byte(fb[i], i == 0);
            if (toggle) @(negedge clk);
        end
`ifdef FRAME_CHECKSUM_EN
        if (bad) ck = ck ^ 8'h01;
        send_byte(ck, 1'b0);
`else
        if (bad) ck = 8'h00;
`endif
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 42; i++) fb[i] = 8'(i);
    endtask

    task automatic test_reset();
        fill_linear();
        send_frame(0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), i == 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (linear_mem1 !== 56'h0) begin
            failed++;
            $display("FAIL reset_mem1: got %h required 0", linear_mem1);
        end
        tests++;
        if (linear_mem6 !== 56'h0) begin
            failed++;
            $display("FAIL reset_mem6: got %h required 0", linear_mem6);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_ready: got %b required 0", in_ready);
        end
        tests++;
        if (data_enable !== 1'b0 || frame_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_strobes: de=%b err=%b required 0 0",
                     data_enable, frame_err);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_frame();
        int de0;
        fill_linear();
        de0 = de_cnt;
        send_frame(0, 1'b0, 1'b0);
        tests++;
        if (data_enable !== 1'b1) begin
            failed++;
            $display("FAIL frame_de: got %b required 1", data_enable);
        end
        tests++;
        if (linear_mem1 !== 56'h00010203040506) begin
            failed++;
            $display("FAIL frame_mem1: got %h required 00010203040506", linear_mem1);
        end
        tests++;
        if (linear_mem2 !== 56'h0708090a0b0c0d || linear_mem3 !== 56'h0e0f1011121314) begin
            failed++;
            $display("FAIL frame_mem23: got %h %h", linear_mem2, linear_mem3);
        end
        tests++;
        if (linear_mem4 !== 56'h15161718191a1b || linear_mem5 !== 56'h1c1d1e1f202122) begin
            failed++;
            $display("FAIL frame_mem45: got %h %h", linear_mem4, linear_mem5);
        end
        tests++;
        if (linear_mem6 !== 56'h23242526272829) begin
            failed++;
            $display("FAIL frame_mem6: got %h required 23242526272829", linear_mem6);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            failed++;
            $display("FAIL frame_commit_ready: got %b required 0", in_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (de_cnt - de0 !== 1) begin
            failed++;
            $display("FAIL frame_de_count: got %0d required 1", de_cnt - de0);
        end
    endtask

    task automatic test_toggle();
        int de0, lo0;
        fill_linear();
        repeat (2) @(negedge clk);
        de0 = de_cnt;
        lo0 = rdy_lo;
        send_frame(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (de_cnt - de0 !== 1) begin
            failed++;
            $display("FAIL toggle_de_count: got %0d required 1", de_cnt - de0);
        end
        tests++;
        if (rdy_lo - lo0 !== 1) begin
            failed++;
            $display("FAIL toggle_ready_low: got %0d cycles required 1", rdy_lo - lo0);
        end
        tests++;
        if (linear_mem1 !== 56'h00010203040506 || linear_mem6 !== 56'h23242526272829) begin
            failed++;
            $display("FAIL toggle_mem: got %h %h", linear_mem1, linear_mem6);
        end
    endtask

    task automatic test_abort();
        int de0, err0;
        de0  = de_cnt;
        err0 = err_cnt;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h60 + i), i == 0);
        send_byte(8'hAA, 1'b1);
        tests++;
        if (frame_err !== 1'b1 || data_enable !== 1'b0) begin
            failed++;
            $display("FAIL abort_err_pulse: err=%b de=%b required 1 0",
                     frame_err, data_enable);
        end
        fb[0] = 8'hAA;
        for (int i = 1; i < 42; i++) fb[i] = 8'(i);
        send_frame(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (linear_mem1 !== 56'hAA010203040506) begin
            failed++;
            $display("FAIL abort_mem1: got %h required aa010203040506", linear_mem1);
        end
        tests++;
        if (de_cnt - de0 !== 1 || err_cnt - err0 !== 1) begin
            failed++;
            $display("FAIL abort_counts: de=%0d err=%0d required 1 1",
                     de_cnt - de0, err_cnt - err0);
        end
    endtask

    task automatic test_no_sof();
        int de0;
        de0 = de_cnt;
        for (int i = 0; i < 6; i++) send_byte(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (de_cnt - de0 !== 0) begin
            failed++;
            $display("FAIL nosof_de: got %0d required 0", de_cnt - de0);
        end
        tests++;
        if (linear_mem1 !== 56'hAA010203040506 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL nosof_hold: mem1=%h rdy=%b required aa010203040506 1",
                     linear_mem1, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int de0;
        de0 = de_cnt;
        for (int i = 0; i < 42; i++) fb[i] = 8'(8'hC0 + i);
        send_frame(0, 1'b0, 1'b0);
        tests++;
        if (linear_mem1 !== 56'hC0C1C2C3C4C5C6 || linear_mem6 !== 56'hE3E4E5E6E7E8E9) begin
            failed++;
            $display("FAIL b2b_first: got %h %h", linear_mem1, linear_mem6);
        end
        fill_linear();
        send_frame(0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if (linear_mem1 !== 56'h00010203040506 || de_cnt - de0 !== 2) begin
            failed++;
            $display("FAIL b2b_second: mem1=%h de=%0d required 00010203040506 2",
                     linear_mem1, de_cnt - de0);
        end
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        int de0;
        for (int i = 0; i < 42; i++) fb[i] = 8'(8'h80 + i);
        send_frame(0, 1'b0, 1'b0);
        tests++;
        if (data_enable !== 1'b1 || linear_mem1 !== 56'h80818283848586) begin
            failed++;
            $display("FAIL ck_good: de=%b mem1=%h required 1 80818283848586",
                     data_enable, linear_mem1);
        end
        repeat (2) @(negedge clk);
        de0 = de_cnt;
        fill_linear();
        send_frame(0, 1'b0, 1'b1);
        tests++;
        if (frame_err !== 1'b1 || data_enable !== 1'b0) begin
            failed++;
            $display("FAIL ck_bad_err: err=%b de=%b required 1 0", frame_err, data_enable);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (linear_mem1 !== 56'h80818283848586 || de_cnt - de0 !== 0) begin
            failed++;
            $display("FAIL ck_bad_hold: mem1=%h de=%0d required 80818283848586 0",
                     linear_mem1, de_cnt - de0);
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_frame();
        test_toggle();
        test_abort();
        test_no_sof();
        test_back_to_back();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        tests++;
        if (both_cnt !== 0) begin
            failed++;
            $display("FAIL de_err_overlap: got %0d cycles required 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
